// File: rtl/adc_range_monitor.sv
// Per-channel min/max/clip range monitor on the ADC sample bus, with windowed snapshots and a registered read port.
// Optional clip counting is built when ADC_RANGE_MONITOR_CLIP_COUNT_EN is defined.
module adc_range_monitor #(
  parameter int CHANNEL_COUNT     = 8,
  parameter int SAMPLES_PER_CLOCK = 2,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int ADC_WIDTH         = 14,
  parameter int WINDOW_WIDTH      = 24,
  parameter int CLIP_WIDTH        = 16,
  parameter int ADDR_WIDTH        = $clog2(CHANNEL_COUNT) + 2
) (
  input  logic                                                  adcClk,
  input  logic                                                  adcReset,
  input  logic [CHANNEL_COUNT*SAMPLES_PER_CLOCK*SAMPLE_WIDTH-1:0] axiData,
  input  logic                                                  latchStrobe,
  input  logic [WINDOW_WIDTH-1:0]                               windowLength,
  input  logic [ADDR_WIDTH-1:0]                                 readAddr,
  output logic [31:0]                                           readData,
  output logic                                                  latchPulse,
  output logic                                                  snapshotValid
);

  localparam int LANES = CHANNEL_COUNT * SAMPLES_PER_CLOCK;
  localparam logic signed [ADC_WIDTH-1:0] FULL_POS = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic signed [ADC_WIDTH-1:0] FULL_NEG = {1'b1, {(ADC_WIDTH-1){1'b0}}};

  typedef logic signed [ADC_WIDTH-1:0] adcT;

  logic [WINDOW_WIDTH-1:0] windowCount;
  logic autoReq;
  logic latchReq;
  logic s1Valid;
  logic s1Req;
  adcT  s1Sample [LANES];
  adcT  redMin [CHANNEL_COUNT];
  adcT  redMax [CHANNEL_COUNT];
  logic s2Valid;
  logic s2Req;
  adcT  s2Min [CHANNEL_COUNT];
  adcT  s2Max [CHANNEL_COUNT];
  adcT  accMin [CHANNEL_COUNT];
  adcT  accMax [CHANNEL_COUNT];
  adcT  mergeMin [CHANNEL_COUNT];
  adcT  mergeMax [CHANNEL_COUNT];
  adcT  snapMin [CHANNEL_COUNT];
  adcT  snapMax [CHANNEL_COUNT];
  logic [7:0] seqCount;
  logic [ADDR_WIDTH-1:0] chanSel;
  logic inRange;
  adcT  selMin;
  adcT  selMax;
  logic [31:0] wordSel;
  logic [31:0] readWord;
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
  localparam int LANE_CLIP_WIDTH = $clog2(SAMPLES_PER_CLOCK + 1);
  logic [LANE_CLIP_WIDTH-1:0] redClips [CHANNEL_COUNT];
  logic [LANE_CLIP_WIDTH-1:0] s2Clips [CHANNEL_COUNT];
  logic [CLIP_WIDTH-1:0] accClips [CHANNEL_COUNT];
  logic [CLIP_WIDTH-1:0] mergeClips [CHANNEL_COUNT];
  logic [CLIP_WIDTH-1:0] snapClips [CHANNEL_COUNT];
  logic [CLIP_WIDTH-1:0] selClips;
  logic [CLIP_WIDTH:0]   clipSum;
`endif

  // Window close request: manual strobe or auto interval expiry (also fires if the length shrinks below the count).
  always_comb begin
    autoReq  = (windowLength != {WINDOW_WIDTH{1'b0}}) &&
               (windowCount >= windowLength - WINDOW_WIDTH'(1));
    latchReq = latchStrobe | autoReq;
  end

  // Stage 1: capture the converter bits of every lane plus the request that closes on this sample.
  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      s1Valid     <= 1'b0;
      s1Req       <= 1'b0;
      windowCount <= {WINDOW_WIDTH{1'b0}};
      for (int i = 0; i < LANES; i++) s1Sample[i] <= {ADC_WIDTH{1'b0}};
    end else begin
      s1Valid     <= 1'b1;
      s1Req       <= latchReq;
      windowCount <= (latchReq || windowLength == {WINDOW_WIDTH{1'b0}}) ?
                     {WINDOW_WIDTH{1'b0}} : windowCount + WINDOW_WIDTH'(1);
      for (int i = 0; i < LANES; i++)
        s1Sample[i] <= axiData[i*SAMPLE_WIDTH + SAMPLE_WIDTH - ADC_WIDTH +: ADC_WIDTH];
    end
  end

  // Lane reduction: fold all lanes of a channel into one min/max/clip-count triple.
  always_comb begin
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      redMin[c] = FULL_POS;
      redMax[c] = FULL_NEG;
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
      redClips[c] = {LANE_CLIP_WIDTH{1'b0}};
`endif
      for (int s = 0; s < SAMPLES_PER_CLOCK; s++) begin
        redMin[c] = (s1Sample[c*SAMPLES_PER_CLOCK+s] < redMin[c]) ? s1Sample[c*SAMPLES_PER_CLOCK+s] : redMin[c];
        redMax[c] = (s1Sample[c*SAMPLES_PER_CLOCK+s] > redMax[c]) ? s1Sample[c*SAMPLES_PER_CLOCK+s] : redMax[c];
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
        redClips[c] = redClips[c] + ((s1Sample[c*SAMPLES_PER_CLOCK+s] == FULL_POS ||
                                      s1Sample[c*SAMPLES_PER_CLOCK+s] == FULL_NEG) ?
                                     LANE_CLIP_WIDTH'(1) : LANE_CLIP_WIDTH'(0));
`endif
      end
    end
  end

  // Stage 2: register the per-channel reduction.
  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      s2Valid <= 1'b0;
      s2Req   <= 1'b0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        s2Min[c] <= FULL_POS;
        s2Max[c] <= FULL_NEG;
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
        s2Clips[c] <= {LANE_CLIP_WIDTH{1'b0}};
`endif
      end
    end else begin
      s2Valid <= s1Valid;
      s2Req   <= s1Req & s1Valid;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        s2Min[c] <= redMin[c];
        s2Max[c] <= redMax[c];
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
        s2Clips[c] <= redClips[c];
`endif
      end
    end
  end

  // Accumulator merged with the incoming stage-2 value; clip total saturates at all-ones.
  always_comb begin
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
    clipSum = {(CLIP_WIDTH+1){1'b0}};
`endif
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      mergeMin[c] = (s2Min[c] < accMin[c]) ? s2Min[c] : accMin[c];
      mergeMax[c] = (s2Max[c] > accMax[c]) ? s2Max[c] : accMax[c];
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
      clipSum       = {1'b0, accClips[c]} + (CLIP_WIDTH+1)'(s2Clips[c]);
      mergeClips[c] = clipSum[CLIP_WIDTH] ? {CLIP_WIDTH{1'b1}} : clipSum[CLIP_WIDTH-1:0];
`endif
    end
  end

  // Stage 3: accumulate, or on a closing sample freeze the merged window and restart empty.
  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      seqCount      <= 8'd0;
      latchPulse    <= 1'b0;
      snapshotValid <= 1'b0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        accMin[c]  <= FULL_POS;
        accMax[c]  <= FULL_NEG;
        snapMin[c] <= {ADC_WIDTH{1'b0}};
        snapMax[c] <= {ADC_WIDTH{1'b0}};
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
        accClips[c]  <= {CLIP_WIDTH{1'b0}};
        snapClips[c] <= {CLIP_WIDTH{1'b0}};
`endif
      end
    end else begin
      latchPulse <= s2Valid & s2Req;
      if (s2Valid && s2Req) begin
        seqCount      <= seqCount + 8'd1;
        snapshotValid <= 1'b1;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
          snapMin[c] <= mergeMin[c];
          snapMax[c] <= mergeMax[c];
          accMin[c]  <= FULL_POS;
          accMax[c]  <= FULL_NEG;
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
          snapClips[c] <= mergeClips[c];
          accClips[c]  <= {CLIP_WIDTH{1'b0}};
`endif
        end
      end else if (s2Valid) begin
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
          accMin[c] <= mergeMin[c];
          accMax[c] <= mergeMax[c];
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
          accClips[c] <= mergeClips[c];
`endif
        end
      end
    end
  end

  // Read word select; addresses past the last channel return zero.
  always_comb begin
    chanSel = readAddr >> 2;
    inRange = {1'b0, readAddr} < (ADDR_WIDTH+1)'(CHANNEL_COUNT * 4);
    selMin  = {ADC_WIDTH{1'b0}};
    selMax  = {ADC_WIDTH{1'b0}};
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
    selClips = {CLIP_WIDTH{1'b0}};
`endif
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      selMin = (chanSel == ADDR_WIDTH'(c)) ? snapMin[c] : selMin;
      selMax = (chanSel == ADDR_WIDTH'(c)) ? snapMax[c] : selMax;
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
      selClips = (chanSel == ADDR_WIDTH'(c)) ? snapClips[c] : selClips;
`endif
    end
    case (readAddr[1:0])
      2'd0:    wordSel = 32'(selMin);
      2'd1:    wordSel = 32'(selMax);
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
      2'd2:    wordSel = 32'(selClips);
`else
      2'd2:    wordSel = 32'd0;
`endif
      2'd3:    wordSel = {24'd0, seqCount};
      default: wordSel = 32'd0;
    endcase
    readWord = inRange ? wordSel : 32'd0;
  end

  // Registered read port.
  always_ff @(posedge adcClk) begin
    if (adcReset) readData <= 32'd0;
    else          readData <= readWord;
  end

endmodule

// File: tb/tb_adc_range_monitor.sv
// Self-checking bench for adc_range_monitor: window-level model plus directed literal checks.
// A second instance (6 channels, 4-bit clip counter) covers clip saturation and the unmapped address range.
module tb_adc_range_monitor;
  localparam int CC = 8, SPC = 2, SW = 16, AW = 14, WW = 24, CW = 16, AD = 5;
  localparam int CC2 = 6, CW2 = 4;
  localparam int FPOS = 8191, FNEG = -8192;

  logic adcClk = 1'b0;
  always #5 adcClk = ~adcClk;

  logic adcReset = 1'b1;
  logic [CC*SPC*SW-1:0] axiData = '0;
  logic latchStrobe = 1'b0;
  logic [WW-1:0] windowLength = '0;
  logic [AD-1:0] readAddr = '0;
  logic [31:0] readData, readData2;
  logic latchPulse, latchPulse2, snapshotValid, snapshotValid2;

  adc_range_monitor dut (
    .adcClk(adcClk), .adcReset(adcReset), .axiData(axiData), .latchStrobe(latchStrobe),
    .windowLength(windowLength), .readAddr(readAddr), .readData(readData),
    .latchPulse(latchPulse), .snapshotValid(snapshotValid));

  adc_range_monitor #(.CHANNEL_COUNT(CC2), .CLIP_WIDTH(CW2)) dut2 (
    .adcClk(adcClk), .adcReset(adcReset), .axiData(axiData[CC2*SPC*SW-1:0]), .latchStrobe(latchStrobe),
    .windowLength(windowLength), .readAddr(readAddr), .readData(readData2),
    .latchPulse(latchPulse2), .snapshotValid(snapshotValid2));

  int checks = 0, failures = 0, cycleNo = 0;
  bit checking = 1'b0;
  int laneVal [CC*SPC];
  int curMin [CC], curMax [CC], curClips [CC];
  int snMin [CC], snMax [CC], snClips [CC];
  int seq = 0, cnt = 0;
  bit pulseAt [int];
  bit vEv [int];
  bit curV = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  function automatic void emptyWindow();
    for (int c = 0; c < CC; c++) begin
      curMin[c] = FPOS; curMax[c] = FNEG; curClips[c] = 0;
    end
  endfunction

  function automatic logic [31:0] expWord(input int addr, input int cc, input int cw);
    int c, k, sat;
    if (addr >= cc * 4) return 32'd0;
    c = addr / 4; k = addr % 4;
    sat = (1 << cw) - 1;
    case (k)
      0: return 32'(snMin[c]);
      1: return 32'(snMax[c]);
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
      2: return 32'((snClips[c] > sat) ? sat : snClips[c]);
`else
      2: return 32'd0;
`endif
      default: return 32'(seq);
    endcase
  endfunction

  // Window-level model for the cycle whose inputs are currently applied.
  task automatic modelStep();
    bit autoReq, req;
    if (adcReset) begin
      for (int d = 1; d <= 3; d++) begin
        if (pulseAt.exists(cycleNo + d)) pulseAt.delete(cycleNo + d);
        if (vEv.exists(cycleNo + d)) vEv.delete(cycleNo + d);
      end
      vEv[cycleNo + 1] = 1'b0;
      emptyWindow();
      for (int c = 0; c < CC; c++) begin snMin[c] = 0; snMax[c] = 0; snClips[c] = 0; end
      seq = 0; cnt = 0;
    end else begin
      for (int c = 0; c < CC; c++)
        for (int s = 0; s < SPC; s++) begin
          int v;
          v = laneVal[c*SPC+s];
          if (v < curMin[c]) curMin[c] = v;
          if (v > curMax[c]) curMax[c] = v;
          if (v == FPOS || v == FNEG) curClips[c]++;
        end
      autoReq = (windowLength != 0) && (cnt == int'(windowLength) - 1);
      req = latchStrobe || autoReq;
      cnt = (req || windowLength == 0) ? 0 : cnt + 1;
      if (req) begin
        for (int c = 0; c < CC; c++) begin
          snMin[c] = curMin[c]; snMax[c] = curMax[c]; snClips[c] = curClips[c];
        end
        seq = (seq + 1) % 256;
        pulseAt[cycleNo + 3] = 1'b1;
        vEv[cycleNo + 3] = 1'b1;
        emptyWindow();
      end
    end
  endtask

  task automatic step();
    for (int i = 0; i < CC*SPC; i++) begin
      logic [SW-1:0] lane;
      lane = SW'(laneVal[i] <<< (SW - AW));
      lane[1:0] = 2'b10;
      axiData[i*SW +: SW] = lane;
    end
    modelStep();
    @(posedge adcClk);
    cycleNo++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input int addr, input string name, input bit hasLit,
                    input logic [31:0] lit1, input logic [31:0] lit2);
    readAddr = AD'(addr);
    step();
    check({name, "_model"}, readData, expWord(addr, CC, CW));
    check({name, "_model2"}, readData2, expWord(addr, CC2, CW2));
    if (hasLit) begin
      check(name, readData, lit1);
      check({name, "_2"}, readData2, lit2);
    end
  endtask

  // Per-cycle compare of the handshake outputs against the model's expectations.
  always @(negedge adcClk) begin
    if (vEv.exists(cycleNo)) curV = vEv[cycleNo];
    if (checking) begin
      check("latchPulse", latchPulse, pulseAt.exists(cycleNo));
      check("latchPulse2", latchPulse2, pulseAt.exists(cycleNo));
      check("snapshotValid", snapshotValid, curV);
      check("snapshotValid2", snapshotValid2, curV);
    end
  end

  initial begin
    for (int i = 0; i < CC*SPC; i++) laneVal[i] = 5;
    emptyWindow();
    idle(3);
    checking = 1'b1;
    adcReset = 1'b0;
    check("reset_readData", readData, 32'd0);
    check("reset_valid", snapshotValid, 1'b0);
    rd(0, "rst_min0", 1'b1, 32'd0, 32'd0);
    rd(31, "rst_seq7", 1'b1, 32'd0, 32'd0);

    // Ramp on ch0 -100..+100, others constant 5.
    for (int j = 0; j <= 100; j++) begin
      laneVal[0] = -100 + 2*j;
      laneVal[1] = (j == 100) ? 100 : -99 + 2*j;
      latchStrobe = (j == 100);
      step();
    end
    latchStrobe = 1'b0;
    for (int i = 0; i < 2; i++) laneVal[i] = 5;
    idle(2);
    check("ramp_pulse_L3", latchPulse, 1'b1);
    idle(2);
    rd(0, "ramp_min", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FF9C);
    rd(1, "ramp_max", 1'b1, 32'd100, 32'd100);
    rd(2, "ramp_clip", 1'b1, 32'd0, 32'd0);
    rd(12, "ch3_min", 1'b1, 32'd5, 32'd5);
    rd(13, "ch3_max", 1'b1, 32'd5, 32'd5);
    rd(3, "ramp_seq", 1'b1, 32'd1, 32'd1);

    // Auto windows of 4 with ch1 lanes 0x1FFF / 0.
    latchStrobe = 1'b1; step(); latchStrobe = 1'b0;
    windowLength = 24'd4; laneVal[2] = FPOS; laneVal[3] = 0;
    idle(12);
    windowLength = 24'd0; laneVal[2] = 5; laneVal[3] = 5;
    idle(4);
    rd(4, "auto_min", 1'b1, 32'd0, 32'd0);
    rd(5, "auto_max", 1'b1, 32'd8191, 32'd8191);
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
    rd(6, "auto_clips", 1'b1, 32'd4, 32'd4);
`else
    rd(6, "auto_clips", 1'b1, 32'd0, 32'd0);
`endif

    // Strobe coincident with auto expiry.
    latchStrobe = 1'b1; step(); latchStrobe = 1'b0;
    windowLength = 24'd4;
    idle(3);
    latchStrobe = 1'b1; step(); latchStrobe = 1'b0;
    idle(4);
    windowLength = 24'd0;
    idle(4);
    rd(3, "coinc_seq", 1'b1, 32'd8, 32'd8);

    // Window boundary: -8192 closes the window, +50 opens the next.
    laneVal[4] = FNEG; laneVal[5] = 0; latchStrobe = 1'b1; step();
    latchStrobe = 1'b0; laneVal[4] = 50; laneVal[5] = 50;
    idle(3);
    rd(8, "bound_min", 1'b1, 32'hFFFF_E000, 32'hFFFF_E000);
    latchStrobe = 1'b1; step(); latchStrobe = 1'b0;
    idle(4);
    rd(8, "next_min", 1'b1, 32'd50, 32'd50);
    rd(9, "next_max", 1'b1, 32'd50, 32'd50);
    rd(11, "bound_seq", 1'b1, 32'd10, 32'd10);
    laneVal[4] = 5; laneVal[5] = 5;

    // 20 clips on ch3: full count vs 4-bit saturation; unmapped address on the 6-channel instance.
    latchStrobe = 1'b1; step(); latchStrobe = 1'b0;
    laneVal[6] = FPOS; laneVal[7] = FPOS;
    idle(9);
    latchStrobe = 1'b1; step(); latchStrobe = 1'b0;
    laneVal[6] = 5; laneVal[7] = 5;
    idle(4);
`ifdef ADC_RANGE_MONITOR_CLIP_COUNT_EN
    rd(14, "clip_sat", 1'b1, 32'd20, 32'd15);
`else
    rd(14, "clip_sat", 1'b1, 32'd0, 32'd0);
`endif
    rd(26, "beyond_map", 1'b0, 32'd0, 32'd0);
    check("beyond_map_2", readData2, 32'd0);

    // 300 latches from reset: sequence wraps to 44.
    adcReset = 1'b1; step(); adcReset = 1'b0;
    latchStrobe = 1'b1;
    idle(300);
    latchStrobe = 1'b0;
    idle(4);
    rd(3, "seq_wrap", 1'b1, 32'd44, 32'd44);

    // Reset two cycles after a strobe discards the pending snapshot.
    latchStrobe = 1'b1; step(); latchStrobe = 1'b0;
    step();
    adcReset = 1'b1; step(); adcReset = 1'b0;
    idle(4);
    check("rst_inflight_valid", snapshotValid, 1'b0);
    rd(0, "rst_inflight_min", 1'b1, 32'd0, 32'd0);
    rd(1, "rst_inflight_max", 1'b1, 32'd0, 32'd0);
    rd(3, "rst_inflight_seq", 1'b1, 32'd0, 32'd0);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_range_monitor.md
# adc_range_monitor

Parametrised ADC-domain range and clipping monitor for the digitizer datapath. Sits on the ADC AXI sample bus and, per physical channel (merging all samples-per-clock lanes of that channel), tracks minimum, maximum and full-scale clip count over a window that closes on a manual strobe or an automatic interval. Closed windows are frozen into a snapshot bank, which is read back through an addressed, registered word port. All logic is in a single clock domain; software access crosses into this domain elsewhere.

## Interface
Parameters:
- CHANNEL_COUNT, 8, physical ADC channels.
- SAMPLES_PER_CLOCK, 2, lanes per channel per clock.
- SAMPLE_WIDTH, 16, lane width on the bus.
- ADC_WIDTH, 14, converter bits, left-justified (MSBs) in each lane, two's complement; 2 ≤ ADC_WIDTH ≤ SAMPLE_WIDTH ≤ 32.
- WINDOW_WIDTH, 24, width of the auto-window length.
- CLIP_WIDTH, 16, clip counter width, ≤ 32.
- ADDR_WIDTH, $clog2(CHANNEL_COUNT)+2, read address width.

Ports:
- adcClk  in  1  sole clock.
- adcReset  in  1  reset; synchronous and active-high.
- axiData  in  CHANNEL_COUNT*SAMPLES_PER_CLOCK*SAMPLE_WIDTH  lane i = ch*SAMPLES_PER_CLOCK+s at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]; every clock carries valid data.
- latchStrobe  in  1  one-cycle manual window close.
- windowLength  in  WINDOW_WIDTH  auto-close interval in clocks; 0 = manual only.
- readAddr  in  ADDR_WIDTH  word select.
- readData  out  32  registered read word.
- latchPulse  out  1  high one cycle when a new snapshot is visible.
- snapshotValid  out  1  at least one snapshot taken since reset.

## Operation
- Pipeline: stage 1 registers axiData with a valid bit; stage 2 registers per-channel lane-reduced min, max, clip-lane count; stage 3 accumulator. Valid bits reset to 0; invalid stages never update accumulators.
- Accumulator per channel: min, max (ADC_WIDTH signed), clips (CLIP_WIDTH unsigned, saturating at all-ones). Empty state: min = +full-scale, max = −full-scale, clips = 0.
- Clip: lane value equals −2^(ADC_WIDTH−1) or 2^(ADC_WIDTH−1)−1; each such lane counts 1.
- Window counter: counts 0..windowLength−1 each clock; at windowLength−1 raises auto request and returns to 0. latchStrobe raises request and clears counter. windowLength = 0 holds counter at 0, no auto request. If windowLength drops to ≤ counter, request next cycle. windowLength = 1: request every cycle.
- Latch request (manual or auto; simultaneous = one latch) travels with the data pipeline. At close: snapshot ← accumulator merged with the stage-2 value of the closing cycle; accumulator ← empty (so the next sample starts the new window); no sample lost or double-counted. sequence (8-bit, wraps 255→0) increments; snapshotValid sets.
- Read map, word k of channel c at address c*4+k: k=0 snapshot min sign-extended to 32; k=1 snapshot max sign-extended; k=2 snapshot clips zero-extended; k=3 {24'b0, sequence}. Addresses ≥ CHANNEL_COUNT*4 read 0.
- adcReset: all pipeline valids, accumulators (empty), snapshots (min=max=clips=0), sequence, counter, readData, latchPulse, snapshotValid to 0 on next edge; a request in flight is discarded.

## Timing
- Sample presented in cycle t enters the accumulator at end of t+2.
- Latch request in cycle L: sample of cycle L is last in the closing window, L+1 first of the next; snapshot and sequence updated at end of L+2; latchPulse high in L+3.
- readAddr in cycle t → readData in t+1; readData reflects snapshot contents as of that edge.
- Auto: windowLength = N, counter starts at reset release; windows cover exactly N samples per channel.

## Configuration
- ADC_RANGE_MONITOR_CLIP_COUNT_EN defined: clip detection and counters built; word k=2 as above.
- Not defined: no clip logic or counters; word k=2 reads 0; min/max, sequence, timing unchanged.

## Test plan
- Reset then ch0 lanes ramp −100..+100, others constant 5, latchStrobe after 201 samples → ch0 min −100, max 100; others 5/5; sequence 1, latchPulse 3 cycles after strobe.
- windowLength = 4, ch1 lanes alternate 0x1FFF / 0 with 14-bit ADC → latchPulse every 4 clocks, each snapshot max 8191, clips 4 (macro on) or 0 (macro off).
- latchStrobe coincident with auto expiry → single snapshot, sequence +1 only, counter restarts at 0.
- Boundary: value −8192 in cycle L, +50 in L+1, strobe at L → snapshot min −8192; next window min 50, no −8192.
- 300 latches → sequence reads 44 (wrap); CLIP_WIDTH=4 with 20 clips → clips 15; readAddr beyond map → 0.
- adcReset asserted two cycles after strobe → no latchPulse, snapshotValid 0, all reads 0.
